// File: rtl/mem_access_ctrl.sv
// MEM-stage data-bus access controller.
// Converts the EX/MEM load/store into a req/addr_ok/data_ok bus transaction
// (one outstanding access at most), builds lane-replicated store data and
// returns the aligned, zero/sign-extended load result. mem_stall_o/data_ok_o
// feed the pipeline stall controller.
//
// Handshake: data_req is held high from the first request cycle until the
// cycle data_addr_ok is seen high (request accepted on that clock edge); the
// response is the single cycle in which data_data_ok is high afterwards.
// Address, size, wr and wdata stay stable while data_req is high because the
// EX/MEM register is frozen by mem_stall_o.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_type,
  input  logic [1:0]        mem_size,
  input  logic              mem_signed,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              pipe_stall_i,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              mem_stall_o,
  output logic              data_ok_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [2:0]        state_dbg
);

  localparam logic [1:0] MEM_LOAD = 2'd1;
  localparam logic [1:0] MEM_STOR = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_ADDR = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_DRAIN     = 3'd3,
    S_HOLD      = 3'd4
  } state_t;

  state_t state;

  logic              is_load;
  logic              is_store;
  logic              misalign;
  logic              access_valid;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [DATA_W-1:0] load_ext;

  assign is_load  = (mem_type == MEM_LOAD);
  assign is_store = (mem_type == MEM_STOR);

  // Address check: halfwords need addr[0]=0, words (size 2 or 3) need addr[1:0]=0
  always_comb begin
    misalign = 1'b0;
    case (mem_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = mem_addr[0];
      default: misalign = (mem_addr[1:0] != 2'b00);
    endcase
  end

  assign adel_o       = is_load & misalign;
  assign ades_o       = is_store & misalign;
  assign access_valid = (is_load | is_store) & ~misalign & ~flush;

  // Bus request side: req is combinational in IDLE so the minimum latency is two cycles
  assign data_req  = ((state == S_IDLE) & access_valid) | (state == S_WAIT_ADDR);
  assign data_wr   = is_store;
  assign data_size = mem_size;
  assign data_addr = mem_addr;

  // Store data is replicated across lanes; the bus picks the lane from addr/size
  always_comb begin
    data_wdata = mem_wdata;
    case (mem_size)
      2'd0:    data_wdata = {4{mem_wdata[7:0]}};
      2'd1:    data_wdata = {2{mem_wdata[15:0]}};
      default: data_wdata = mem_wdata;
    endcase
  end

  // Stall while a request is pending or an accepted access has not returned
  assign mem_stall_o = ((state == S_IDLE) & access_valid) | (state == S_WAIT_ADDR) |
                       (state == S_WAIT_DATA) | (state == S_DRAIN);

  // One-cycle completion pulse; a drained (flushed) access never reports completion
  assign data_ok_o = (state == S_WAIT_DATA) & data_data_ok;

  assign state_dbg = state;

  // Load lane select and extension from the raw bus word
  always_comb begin
    load_byte = data_rdata[7:0];
    case (mem_addr[1:0])
      2'd0: load_byte = data_rdata[7:0];
      2'd1: load_byte = data_rdata[15:8];
      2'd2: load_byte = data_rdata[23:16];
      2'd3: load_byte = data_rdata[31:24];
      default: load_byte = data_rdata[7:0];
    endcase
    load_half = mem_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (mem_size)
      2'd0:    load_ext = {{24{mem_signed & load_byte[7]}}, load_byte};
      2'd1:    load_ext = {{16{mem_signed & load_half[15]}}, load_half};
      default: load_ext = data_rdata;
    endcase
  end

  // Transaction FSM and load result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      rdata_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access_valid) begin
            state <= data_addr_ok ? S_WAIT_DATA : S_WAIT_ADDR;
          end
        end
        S_WAIT_ADDR: begin
          // Once accepted, a killed access must still be drained from the bus
          if (data_addr_ok) begin
            state <= flush ? S_DRAIN : S_WAIT_DATA;
          end else if (flush) begin
            state <= S_IDLE;
          end
        end
        S_WAIT_DATA: begin
          if (data_data_ok) begin
            if (is_load) begin
              rdata_o <= load_ext;
            end
            // HOLD blocks a reissue while EX/MEM still shows the finished access
            state <= (pipe_stall_i && !flush) ? S_HOLD : S_IDLE;
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (data_data_ok) begin
            state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (!pipe_stall_i || flush) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: stimulus pushes expected completions
// into exp_q; a monitor pops one entry per data_ok_o pulse and compares the
// registered load result in the following cycle.
module tb_mem_access_ctrl;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_LOAD = 2'd1;
  localparam logic [1:0] T_STOR = 2'd2;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  mem_type;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        pipe_stall_i;
  logic        flush;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_stall_o;
  logic        data_ok_o;
  logic [31:0] rdata_o;
  logic        adel_o;
  logic        ades_o;
  logic [2:0]  state_dbg;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_type(mem_type), .mem_size(mem_size), .mem_signed(mem_signed),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pipe_stall_i(pipe_stall_i), .flush(flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_stall_o(mem_stall_o), .data_ok_o(data_ok_o), .rdata_o(rdata_o),
    .adel_o(adel_o), .ades_o(ades_o), .state_dbg(state_dbg)
  );

  // scoreboard: bit 32 set = load whose rdata_o must be compared
  logic [32:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // monitor: pop on each completion pulse, compare result one cycle later
  initial begin : monitor
    logic        pend;
    logic [32:0] pe;
    pend = 1'b0;
    pe   = '0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (pe[32]) check("rdata_o result", rdata_o, pe[31:0]);
        pend = 1'b0;
      end
      if (rst && data_ok_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious data_ok_o", {31'd0, data_ok_o}, 32'd0);
        end else begin
          pe   = exp_q.pop_front();
          pend = 1'b1;
        end
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] t, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_type   = t;
    mem_size   = sz;
    mem_signed = sg;
    mem_addr   = a;
    mem_wdata  = wd;
  endtask

  task automatic do_load(input string name, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] raw, input logic [31:0] exp);
    next_cycle();
    drive(T_LOAD, sz, sg, a, 32'd0);
    data_addr_ok = 1'b1;
    exp_q.push_back({1'b1, exp});
    @(negedge clk);
    check({name, " req"}, {31'd0, data_req}, 32'd1);
    check({name, " stall c1"}, {31'd0, mem_stall_o}, 32'd1);
    check({name, " wr"}, {31'd0, data_wr}, 32'd0);
    next_cycle();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = raw;
    @(negedge clk);
    check({name, " stall c2"}, {31'd0, mem_stall_o}, 32'd1);
    check({name, " data_ok_o"}, {31'd0, data_ok_o}, 32'd1);
    check({name, " req c2"}, {31'd0, data_req}, 32'd0);
    next_cycle();
    data_data_ok = 1'b0;
    data_rdata   = $urandom_range(32'h7fff_ffff, 0);
    drive(T_NONE, 2'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check({name, " stall after"}, {31'd0, mem_stall_o}, 32'd0);
  endtask

  initial begin : stimulus
    rst = 1'b0;
    drive(T_NONE, 2'd0, 1'b0, 32'd0, 32'd0);
    pipe_stall_i = 1'b0;
    flush        = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset state", {29'd0, state_dbg}, 32'd0);
    check("reset req", {31'd0, data_req}, 32'd0);
    check("reset stall", {31'd0, mem_stall_o}, 32'd0);
    check("reset data_ok_o", {31'd0, data_ok_o}, 32'd0);
    check("reset rdata_o", rdata_o, 32'd0);

    // 1: LW, minimum latency
    do_load("LW 0x100", 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    // 2: byte/half loads, lane select and extension
    do_load("LB 0x103", 2'd0, 1'b1, 32'h103, 32'h80FF_FF7F, 32'hFFFF_FF80);
    do_load("LBU 0x103", 2'd0, 1'b0, 32'h103, 32'h80FF_FF7F, 32'h0000_0080);
    do_load("LB 0x101", 2'd0, 1'b1, 32'h101, 32'h0000_A500, 32'hFFFF_FFA5);
    do_load("LH 0x102", 2'd1, 1'b1, 32'h102, 32'h8001_7FFF, 32'hFFFF_8001);
    do_load("LHU 0x100", 2'd1, 1'b0, 32'h100, 32'h1234_F00D, 32'h0000_F00D);

    // 3: SH with a late addr_ok
    next_cycle();
    drive(T_STOR, 2'd1, 1'b0, 32'h202, 32'h1234_ABCD);
    exp_q.push_back({1'b0, 32'd0});
    @(negedge clk);
    check("SH req", {31'd0, data_req}, 32'd1);
    check("SH wr", {31'd0, data_wr}, 32'd1);
    check("SH size", {30'd0, data_size}, 32'd1);
    check("SH addr", data_addr, 32'h202);
    check("SH wdata", data_wdata, 32'hABCD_ABCD);
    next_cycle();
    data_addr_ok = 1'b1;
    @(negedge clk);
    check("SH wait_addr state", {29'd0, state_dbg}, 32'd1);
    check("SH req held", {31'd0, data_req}, 32'd1);
    next_cycle();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    @(negedge clk);
    check("SH data_ok_o", {31'd0, data_ok_o}, 32'd1);
    check("SH req done", {31'd0, data_req}, 32'd0);
    next_cycle();
    data_data_ok = 1'b0;
    drive(T_NONE, 2'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("SH stall after", {31'd0, mem_stall_o}, 32'd0);

    // 4: misaligned accesses raise exceptions and never request
    next_cycle();
    drive(T_LOAD, 2'd2, 1'b0, 32'h101, 32'd0);
    @(negedge clk);
    check("LW 0x101 adel", {31'd0, adel_o}, 32'd1);
    check("LW 0x101 ades", {31'd0, ades_o}, 32'd0);
    check("LW 0x101 req", {31'd0, data_req}, 32'd0);
    check("LW 0x101 stall", {31'd0, mem_stall_o}, 32'd0);
    next_cycle();
    drive(T_STOR, 2'd1, 1'b0, 32'h201, 32'd0);
    @(negedge clk);
    check("SH 0x201 ades", {31'd0, ades_o}, 32'd1);
    check("SH 0x201 req", {31'd0, data_req}, 32'd0);
    next_cycle();
    drive(T_STOR, 2'd0, 1'b0, 32'h203, 32'h0000_005A);
    @(negedge clk);
    check("SB 0x203 ades", {31'd0, ades_o}, 32'd0);
    check("SB wdata", data_wdata, 32'h5A5A_5A5A);
    check("SB req", {31'd0, data_req}, 32'd1);

    // 5a: flush in WAIT_ADDR drops the request next cycle
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("flush wait_addr req", {31'd0, data_req}, 32'd1);
    check("flush wait_addr stall", {31'd0, mem_stall_o}, 32'd1);
    next_cycle();
    flush = 1'b0;
    drive(T_NONE, 2'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("flush dropped req", {31'd0, data_req}, 32'd0);
    check("flush dropped state", {29'd0, state_dbg}, 32'd0);

    // 6: pipe_stall at completion -> HOLD without reissue
    next_cycle();
    drive(T_LOAD, 2'd2, 1'b0, 32'h400, 32'd0);
    data_addr_ok = 1'b1;
    exp_q.push_back({1'b1, 32'hCAFE_F00D});
    next_cycle();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'hCAFE_F00D;
    pipe_stall_i = 1'b1;
    @(negedge clk);
    check("hold data_ok_o", {31'd0, data_ok_o}, 32'd1);
    next_cycle();
    data_data_ok = 1'b0;
    data_rdata   = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold no reissue", {31'd0, data_req}, 32'd0);
      check("hold stall", {31'd0, mem_stall_o}, 32'd0);
      check("hold rdata_o", rdata_o, 32'hCAFE_F00D);
      check("hold state", {29'd0, state_dbg}, 32'd4);
      next_cycle();
    end
    pipe_stall_i = 1'b0;
    @(negedge clk);
    check("hold release req", {31'd0, data_req}, 32'd0);
    next_cycle();
    drive(T_NONE, 2'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("hold back idle", {29'd0, state_dbg}, 32'd0);

    // 5b: flush in WAIT_DATA drains silently
    next_cycle();
    drive(T_LOAD, 2'd2, 1'b0, 32'h300, 32'd0);
    data_addr_ok = 1'b1;
    next_cycle();
    data_addr_ok = 1'b0;
    flush        = 1'b1;
    @(negedge clk);
    check("flush wait_data stall", {31'd0, mem_stall_o}, 32'd1);
    next_cycle();
    flush = 1'b0;
    drive(T_NONE, 2'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("drain state", {29'd0, state_dbg}, 32'd3);
    check("drain stall", {31'd0, mem_stall_o}, 32'd1);
    check("drain req", {31'd0, data_req}, 32'd0);
    next_cycle();
    data_data_ok = 1'b1;
    data_rdata   = 32'h1111_1111;
    @(negedge clk);
    check("drain data_ok_o", {31'd0, data_ok_o}, 32'd0);
    check("drain stall at ok", {31'd0, mem_stall_o}, 32'd1);
    next_cycle();
    data_data_ok = 1'b0;
    @(negedge clk);
    check("drain done stall", {31'd0, mem_stall_o}, 32'd0);
    check("drain rdata_o kept", rdata_o, 32'hCAFE_F00D);

    // stray data_data_ok in IDLE is ignored
    next_cycle();
    data_data_ok = 1'b1;
    @(negedge clk);
    check("idle stray data_ok_o", {31'd0, data_ok_o}, 32'd0);
    check("idle stray stall", {31'd0, mem_stall_o}, 32'd0);
    next_cycle();
    data_data_ok = 1'b0;

    // reset mid-transaction, late data_data_ok ignored
    next_cycle();
    drive(T_LOAD, 2'd2, 1'b0, 32'h500, 32'd0);
    data_addr_ok = 1'b1;
    next_cycle();
    data_addr_ok = 1'b0;
    drive(T_NONE, 2'd0, 1'b0, 32'd0, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("mid reset state", {29'd0, state_dbg}, 32'd0);
    check("mid reset stall", {31'd0, mem_stall_o}, 32'd0);
    check("mid reset rdata_o", rdata_o, 32'd0);
    next_cycle();
    rst          = 1'b1;
    data_data_ok = 1'b1;
    data_rdata   = 32'h2222_2222;
    @(negedge clk);
    check("late data_ok_o", {31'd0, data_ok_o}, 32'd0);
    check("late stall", {31'd0, mem_stall_o}, 32'd0);
    next_cycle();
    data_data_ok = 1'b0;
    repeat (2) @(negedge clk);
    check("exp_q drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
